// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder (g0=111, g1=101), one frame = DATA_BITS data + 2 tail symbols.
// First symbol 1 cycle after accept; valid/ready symbol handshake, output held stable under unbounded stall.
module conv_encoder #(
  parameter int DATA_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [1:0]           sym_out,
  output logic                 valid_out,
  input  logic                 sym_ready,
  output logic [2:0]           sym_index,
  output logic                 last_out,
  output logic [7:0]           frame_count
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_IDX      = 3'(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [DATA_BITS-1:0] dbuf_q, dbuf_d;
  logic [1:0]           enc_q, enc_d;   // {s1, s0}, s0 newest
  logic [2:0]           idx_d;
  logic                 vld_d, rdy_d, last_d;
  logic [1:0]           sym_d;
  logic [7:0]           cnt_d;
  logic                 u_next;
  logic                 accept, xfer;

  assign accept = (fsm_q == IDLE) && valid_in && ready_out;
  assign xfer   = valid_out && sym_ready;

  // enc_q/dbuf_q describe the presented step: enc_q is the state before it and
  // dbuf_q MSB is its input bit; zeros shifted in supply the tail bits.
  always_comb begin
    fsm_d  = fsm_q;
    dbuf_d = dbuf_q;
    enc_d  = enc_q;
    idx_d  = sym_index;
    vld_d  = valid_out;
    cnt_d  = frame_count;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          fsm_d  = DATA;
          dbuf_d = data_in;
          enc_d  = 2'b00;
          idx_d  = 3'd0;
          vld_d  = 1'b1;
        end
      end
      DATA: begin
        if (xfer) begin
          enc_d  = {enc_q[0], dbuf_q[DATA_BITS-1]};
          dbuf_d = dbuf_q << 1;
          idx_d  = sym_index + 3'd1;
          if (sym_index == LAST_DATA_IDX) fsm_d = TAIL;
        end
      end
      TAIL: begin
        if (xfer) begin
          enc_d  = {enc_q[0], dbuf_q[DATA_BITS-1]};
          dbuf_d = dbuf_q << 1;
          idx_d  = sym_index + 3'd1;
          if (sym_index == LAST_IDX) begin
            fsm_d = IDLE;
            enc_d = 2'b00;
            idx_d = 3'd0;
            vld_d = 1'b0;
            cnt_d = frame_count + 8'd1;
          end
        end
      end
      default: begin
        fsm_d  = IDLE;
        dbuf_d = '0;
        enc_d  = 2'b00;
        idx_d  = 3'd0;
        vld_d  = 1'b0;
      end
    endcase

    u_next = dbuf_d[DATA_BITS-1];
    sym_d  = vld_d ? {u_next ^ enc_d[0] ^ enc_d[1], u_next ^ enc_d[1]} : 2'b00;
    last_d = vld_d && (idx_d == LAST_IDX);
    rdy_d  = (fsm_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      dbuf_q      <= '0;
      enc_q       <= 2'b00;
      sym_out     <= 2'b00;
      sym_index   <= 3'd0;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
      ready_out   <= 1'b1;
      frame_count <= 8'd0;
    end else begin
      fsm_q       <= fsm_d;
      dbuf_q      <= dbuf_d;
      enc_q       <= enc_d;
      sym_out     <= sym_d;
      sym_index   <= idx_d;
      valid_out   <= vld_d;
      last_out    <= last_d;
      ready_out   <= rdy_d;
      frame_count <= cnt_d;
    end
  end

  // A stalled symbol must stay put until the downstream takes it.
  stall_hold_a: assert property (@(posedge clk) disable iff (!rst)
    (valid_out && !sym_ready) |=> (valid_out && $stable(sym_out) && $stable(sym_index) && $stable(last_out)));

  ready_valid_excl_a: assert property (@(posedge clk) disable iff (!rst)
    !(ready_out && valid_out));

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: hand-computed symbol sequences, stall, ignored input and mid-frame reset.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [1:0] sym_out;
  logic       valid_out;
  logic       sym_ready;
  logic [2:0] sym_index;
  logic       last_out;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  // 8 symbols packed, first symbol in [15:14]
  localparam logic [15:0] SEQ_101100 = 16'b11_10_00_01_01_11_00_00;
  localparam logic [15:0] SEQ_111111 = 16'b11_01_10_10_10_10_01_11;
  localparam logic [15:0] SEQ_000000 = 16'b00_00_00_00_00_00_00_00;

  conv_encoder #(.DATA_BITS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .sym_out    (sym_out),
    .valid_out  (valid_out),
    .sym_ready  (sym_ready),
    .sym_index  (sym_index),
    .last_out   (last_out),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a frame once the encoder is idle; returns presenting symbol 0.
  task automatic send_frame(input logic [5:0] d);
    int k;
    k = 0;
    while (!ready_out && k < 20) begin
      tick();
      k++;
    end
    chk("ready_before_accept", {31'd0, ready_out}, 32'd1);
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
    data_in  = 6'b000000;
  endtask

  // Consume n symbols, checking each; optional stall and an ignored offer mid-frame.
  task automatic recv_frame(input logic [15:0] exp_seq, input int n, input int stall_idx,
                            input int stall_len, input bit inject, input logic [7:0] exp_cnt);
    logic [1:0] es;
    for (int i = 0; i < n; i++) begin
      es = exp_seq[15-2*i -: 2];
      chk($sformatf("valid[%0d]", i), {31'd0, valid_out}, 32'd1);
      chk($sformatf("sym[%0d]", i), {30'd0, sym_out}, {30'd0, es});
      chk($sformatf("index[%0d]", i), {29'd0, sym_index}, i);
      chk($sformatf("last[%0d]", i), {31'd0, last_out}, {31'd0, (i == 7)});
      chk($sformatf("ready_busy[%0d]", i), {31'd0, ready_out}, 32'd0);
      if (i == stall_idx) begin
        sym_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk($sformatf("stall_valid[%0d]", s), {31'd0, valid_out}, 32'd1);
          chk($sformatf("stall_sym[%0d]", s), {30'd0, sym_out}, {30'd0, es});
          chk($sformatf("stall_index[%0d]", s), {29'd0, sym_index}, i);
        end
        sym_ready = 1'b1;
      end
      if (inject && i == 2) begin
        valid_in = 1'b1;
        data_in  = 6'b111111;
      end
      tick();
      valid_in = 1'b0;
      data_in  = 6'b000000;
    end
    if (n == 8) begin
      chk("valid_after_frame", {31'd0, valid_out}, 32'd0);
      chk("ready_after_frame", {31'd0, ready_out}, 32'd1);
      chk("frame_count", {24'd0, frame_count}, {24'd0, exp_cnt});
    end
  endtask

  initial begin
    rst       = 1'b0;
    data_in   = 6'b000000;
    valid_in  = 1'b0;
    sym_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_sym", {30'd0, sym_out}, 32'd0);
    chk("rst_index", {29'd0, sym_index}, 32'd0);
    chk("rst_last", {31'd0, last_out}, 32'd0);
    chk("rst_count", {24'd0, frame_count}, 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_ready", {31'd0, ready_out}, 32'd1);

    send_frame(6'b101100);
    recv_frame(SEQ_101100, 8, -1, 0, 1'b0, 8'd1);

    send_frame(6'b111111);
    recv_frame(SEQ_111111, 8, -1, 0, 1'b0, 8'd2);

    send_frame(6'b000000);
    recv_frame(SEQ_000000, 8, -1, 0, 1'b0, 8'd3);

    send_frame(6'b101100);
    recv_frame(SEQ_101100, 8, 3, 5, 1'b0, 8'd4);

    send_frame(6'b101100);
    recv_frame(SEQ_101100, 8, -1, 0, 1'b1, 8'd5);

    // Reset while presenting index 4 discards the frame
    send_frame(6'b101100);
    recv_frame(SEQ_101100, 4, -1, 0, 1'b0, 8'd0);
    chk("pre_reset_index", {29'd0, sym_index}, 32'd4);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, valid_out}, 32'd0);
    chk("midrst_sym", {30'd0, sym_out}, 32'd0);
    chk("midrst_index", {29'd0, sym_index}, 32'd0);
    chk("midrst_last", {31'd0, last_out}, 32'd0);
    chk("midrst_count", {24'd0, frame_count}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("postrst_ready", {31'd0, ready_out}, 32'd1);
    send_frame(6'b111111);
    recv_frame(SEQ_111111, 8, -1, 0, 1'b0, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter: DATA_BITS, default 6, information bits per frame (legal 1..6); frame length = DATA_BITS + 2 tail symbols.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port: data_in  input  DATA_BITS  frame information bits, MSB encoded first.
REQ-005 SHALL have port: valid_in  input  1  data_in valid.
REQ-006 SHALL have port: ready_out  output  1  encoder can accept a frame.
REQ-007 SHALL have port: sym_out  output  2  coded symbol; [1] = g0 (111) output, [0] = g1 (101) output.
REQ-008 SHALL have port: valid_out  output  1  sym_out valid.
REQ-009 SHALL have port: sym_ready  input  1  downstream accepts sym_out.
REQ-010 SHALL have port: sym_index  output  3  trellis step of presented symbol, 0..DATA_BITS+1.
REQ-011 SHALL have port: last_out  output  1  presented symbol is the final tail symbol.
REQ-012 SHALL have port: frame_count  output  8  completed frames, wraps 255->0.

Function
REQ-013 SHALL implement rate-1/2, K=3 code over state {s1,s0} (s0 newest): g0 = u^s0^s1, g1 = u^s1; next state = {s0,u}.
REQ-014 SHALL start every frame from state 00 and append two u=0 tail steps, so that every frame ends in state 00.
REQ-015 SHALL use FSM IDLE -> DATA -> TAIL -> IDLE; ready_out = 1 only in IDLE, registered.
REQ-016 SHALL, in IDLE, accept a frame on valid_in && ready_out: latch data_in, clear state, and next cycle present symbol 0 with valid_out=1, sym_index=0.
REQ-017 SHALL treat a symbol as transferred on valid_out && sym_ready; the encoder state, bit pointer and sym_index SHALL advance only on a transfer.
REQ-018 SHALL hold sym_out, sym_index, last_out and valid_out stable while valid_out=1 and sym_ready=0 (unbounded stall).
REQ-019 SHALL move DATA->TAIL after the transfer of index DATA_BITS-1, and TAIL->IDLE after the transfer of index DATA_BITS+1.
REQ-020 SHALL assert last_out only while presenting index DATA_BITS+1.
REQ-021 SHALL, on the final transfer: set valid_out=0 and ready_out=1 on the next cycle, and increment frame_count; a new frame is accepted no earlier than 1 cycle after the final transfer (1-cycle gap).
REQ-022 SHALL ignore valid_in and data_in outside IDLE; the latched frame is unaffected.
REQ-023 SHALL drive sym_out from registers, with no combinational path from sym_ready or valid_in to any output.
REQ-024 SHALL deliver exactly DATA_BITS+2 transfers per accepted frame, with no duplication or skips.

Reset
REQ-025 SHALL, on rst=0 at any time: FSM=IDLE, ready_out=1 after release, valid_out=0, sym_out=00, sym_index=0, last_out=0, frame_count=0, encoder state=00, data buffer=0.
REQ-026 SHALL discard a partially sent frame on mid-frame reset, without incrementing frame_count; after release, the first frame SHALL encode from state 00.

Verification
REQ-027 SHALL cover: data_in=101100, sym_ready=1 -> sym_out sequence 11,10,00,01,01,11,00,00; last_out on 8th; frame_count 0->1.
REQ-028 SHALL cover: data_in=111111 -> 11,01,10,10,10,10,01,11; sym_index 0..7.
REQ-029 SHALL cover: data_in=000000 -> eight 00 symbols; ready_out low for the whole frame and high 1 cycle after the last transfer.
REQ-030 SHALL cover: 101100 with sym_ready low for 5 cycles at index 3 -> sym_out=01, sym_index=3 held stable; the sequence resumes unchanged.
REQ-031 SHALL cover: valid_in pulsed with 111111 during a 101100 frame -> ignored; output matches REQ-027.
REQ-032 SHALL cover: rst=0 at index 4, then frame 111111 -> outputs reset immediately; the new output matches REQ-028; frame_count=1 after completion.
